beta_csr_perf_counters: RTL
===========================

BETA_CSR_PERF_COUNTERS -- requirements
Module: beta_csr_perf_counters

Interface
REQ-001 SHALL have parameter DataWidth, 32, CSR data width (only 32 supported).
REQ-002 SHALL have parameter NumHpmCounters, 4, implemented mhpmcounter3.. count (0..29).
REQ-003 SHALL have parameter CounterWidth, 64, implemented bits per counter (33..64); upper bits read 0.
REQ-004 SHALL have parameter NumEvents, 8, width of hpm event input vector (1..31).
REQ-005 SHALL have port clk_i  in  1  clock; one clock, all state on rising edge.
REQ-006 SHALL have port rstn_i  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port csr_addr_i  in  12  CSR address.
REQ-008 SHALL have port csr_wdata_i  in  DataWidth  write/set/clear operand.
REQ-009 SHALL have port csr_op_i  in  3  [2]=read; [1:0]: 11 write, 01 set, 10 clear, 00 none.
REQ-010 SHALL have port csr_en_i  in  1  CSR access valid this cycle.
REQ-011 SHALL have port csr_priv_lvl_i  in  2  current privilege: 2'b11 M, 2'b00 U.
REQ-012 SHALL have port instr_retire_i  in  1  one instruction retires this cycle.
REQ-013 SHALL have port hpm_event_i  in  NumEvents  event pulses, bit e = event e+1.
REQ-014 SHALL have port csr_rdata_o  out  DataWidth  read data, combinational.
REQ-015 SHALL have port csr_hit_o  out  1  address decoded by this block.
REQ-016 SHALL have port csr_illegal_o  out  1  access raises illegal-instruction.

Function
REQ-017 SHALL decode: mcycle 0xB00/0xB80(h), minstret 0xB02/0xB82, mhpmcounterK 0xB00+K/0xB80+K (K=3..31), mcountinhibit 0x320, mhpmeventK 0x320+K, mcounteren 0x306, shadows cycle 0xC00/0xC80, instret 0xC02/0xC82, hpmcounterK 0xC00+K/0xC80+K.
REQ-018 SHALL assert csr_hit_o combinationally for any listed address when csr_en_i=1, including unimplemented K (≥3+NumHpmCounters), which are read-zero/write-ignore.
REQ-019 SHALL increment mcycle by 1 every cycle while mcountinhibit[0]=0.
REQ-020 SHALL increment minstret by 1 in a cycle with instr_retire_i=1 and mcountinhibit[2]=0.
REQ-021 SHALL increment mhpmcounterK by 1 in a cycle where mhpmeventK=e, 1≤e≤NumEvents, hpm_event_i[e-1]=1, mcountinhibit[K]=0; e=0 never counts.
REQ-022 SHALL store mhpmeventK as WARL, clog2(NumEvents+1) bits; an operation result >NumEvents stores 0.
REQ-023 SHALL wrap counters from 2^CounterWidth-1 to 0, carry propagating low to high half in the same cycle.
REQ-024 SHALL apply write/set/clear to low half (bits 31:0) or high half (bits CounterWidth-1:32) only, other half keeping its current value; on that cycle the counter does not increment (software write wins).
REQ-025 SHALL hardwire mcountinhibit[1] and mcounteren[1] to 0 (no time CSR) and bits for unimplemented K to 0.
REQ-026 SHALL drive csr_rdata_o with selected register value (pre-update) when csr_en_i=1 and csr_op_i[2]=1 and csr_illegal_o=0, else 0.
REQ-027 SHALL make shadows return the same value as the matching M counter.
REQ-028 SHALL assert csr_illegal_o when: M-address accessed with priv≠11; any write/set/clear to a shadow; U-mode shadow access with mcounteren bit (0 cycle, 2 instret, K hpm) clear.
REQ-029 SHALL suppress all state updates of an illegal access.
REQ-030 SHALL treat set/clear with operand 0 as no-modification but still count that cycle.

Reset
REQ-031 SHALL on rstn_i=0 asynchronously clear all counters, mcountinhibit, mcounteren, mhpmevent registers to 0.
REQ-032 SHALL keep csr_rdata_o, csr_hit_o, csr_illegal_o at 0 during reset; counting resumes the first edge after rstn_i rises.
REQ-033 SHALL abandon any access in progress on reset; no partial write survives.

Verification
REQ-034 Reset, run 10 cycles, M read 0xB00 -> 10; read 0xB02 with no retires -> 0.
REQ-035 M write 0xB00=0xFFFFFFFF, 0xB80=0 (CounterWidth=64), wait 1 cycle -> 0xB00 reads 0, 0xB80 reads 1.
REQ-036 Write mhpmevent3=2, pulse hpm_event_i[1] 5 times, hpm_event_i[0] 3 times -> mhpmcounter3=5; write mhpmevent3=NumEvents+1 -> reads 0.
REQ-037 Set mcountinhibit[0], wait 20 cycles -> mcycle unchanged; write 0xB00=7 same cycle as count -> reads 7 next cycle.
REQ-038 U-mode read 0xC00 with mcounteren=0 -> illegal=1, rdata=0; after M sets mcounteren[0] -> illegal=0, value returned; U write 0xC00 -> illegal=1, no change.
REQ-039 Assert rstn_i mid-write to 0xB02 -> minstret=0 after reset.

Source files
------------

// File: rtl/beta_csr_perf_counters.sv
// Machine/user performance-counter CSR block: mcycle, minstret, mhpmcounterK,
// their event selectors, mcountinhibit, mcounteren and the user-mode shadows.
module beta_csr_perf_counters #(
  parameter int DataWidth      = 32,
  parameter int NumHpmCounters = 4,
  parameter int CounterWidth   = 64,
  parameter int NumEvents      = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [DataWidth-1:0] csr_wdata_i,
  input  logic [2:0]           csr_op_i,
  input  logic                 csr_en_i,
  input  logic [1:0]           csr_priv_lvl_i,
  input  logic                 instr_retire_i,
  input  logic [NumEvents-1:0] hpm_event_i,
  output logic [DataWidth-1:0] csr_rdata_o,
  output logic                 csr_hit_o,
  output logic                 csr_illegal_o
);

  localparam int HiW         = CounterWidth - 32;
  localparam int EvW         = $clog2(NumEvents + 1);
  localparam int EvPadW      = 1 << EvW;
  localparam int NumHpmSlots = (NumHpmCounters > 0) ? NumHpmCounters : 1;

  // Counter numbers that physically exist: cycle (0), instret (2), hpm 3..
  function automatic logic [31:0] impl_mask();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int k = 3; k < 32; k++) begin
      if (k < 3 + NumHpmCounters) m[k] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [31:0] ImplMask = impl_mask();

  typedef logic [CounterWidth-1:0] cnt_t;

  typedef enum logic [2:0] {
    KIND_NONE,
    KIND_MCNT,
    KIND_SCNT,
    KIND_INHIBIT,
    KIND_EVENT,
    KIND_COUNTEREN
  } csr_kind_e;

  cnt_t           mcycle_q;
  cnt_t           minstret_q;
  cnt_t           hpm_cnt_q [NumHpmSlots];
  logic [EvW-1:0] hpm_evt_q [NumHpmSlots];
  logic [31:0]    inhibit_q;
  logic [31:0]    counteren_q;

  logic [4:0]  idx;
  logic        hi_half;
  csr_kind_e   kind;
  logic        hit;
  logic        illegal;
  logic        wr_en;
  logic        wr_cnt;
  cnt_t        sel_cnt;
  logic [31:0] sel_evt;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic [EvPadW-1:0]      ev_pad;
  logic [NumHpmSlots-1:0] hpm_fire;

  assign idx     = csr_addr_i[4:0];
  assign hi_half = csr_addr_i[7];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    kind = KIND_NONE;
    if (csr_addr_i[6:5] == 2'b00 && idx != 5'd1) begin
      if (csr_addr_i[11:8] == 4'hB)      kind = KIND_MCNT;
      else if (csr_addr_i[11:8] == 4'hC) kind = KIND_SCNT;
    end
    if (csr_addr_i == 12'h320)                              kind = KIND_INHIBIT;
    else if (csr_addr_i[11:5] == 7'b0011_001 && idx >= 5'd3) kind = KIND_EVENT;
    else if (csr_addr_i == 12'h306)                         kind = KIND_COUNTEREN;
  end

  // Reset gates the decode so the outputs stay quiet while rstn_i is low.
  assign hit = rstn_i & csr_en_i & (kind != KIND_NONE);

  always_comb begin
    illegal = 1'b0;
    if (hit) begin
      if (kind != KIND_SCNT) begin
        illegal = (csr_priv_lvl_i != 2'b11);
      end else begin
        illegal = (csr_op_i[1:0] != 2'b00) ||
                  (csr_priv_lvl_i == 2'b00 && !counteren_q[idx]);
      end
    end
  end

  always_comb begin
    sel_cnt = '0;
    sel_evt = '0;
    if (idx == 5'd0)      sel_cnt = mcycle_q;
    else if (idx == 5'd2) sel_cnt = minstret_q;
    for (int k = 0; k < NumHpmSlots; k++) begin
      if (k < NumHpmCounters && idx == 5'(k + 3)) begin
        sel_cnt = hpm_cnt_q[k];
        sel_evt = 32'(hpm_evt_q[k]);
      end
    end
  end

  always_comb begin
    old_val = '0;
    unique case (kind)
      KIND_MCNT, KIND_SCNT: old_val = hi_half ? 32'(sel_cnt[CounterWidth-1:32]) : sel_cnt[31:0];
      KIND_INHIBIT:         old_val = inhibit_q;
      KIND_EVENT:           old_val = sel_evt;
      KIND_COUNTEREN:       old_val = counteren_q;
      default:              old_val = '0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    unique case (csr_op_i[1:0])
      2'b11:   new_val = csr_wdata_i;
      2'b01:   new_val = old_val | csr_wdata_i;
      2'b10:   new_val = old_val & ~csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  // Set/clear with a zero operand modifies nothing, so it must not steal the increment.
  assign wr_en  = hit & ~illegal &
                  ((csr_op_i[1:0] == 2'b11) || (csr_op_i[1:0] != 2'b00 && csr_wdata_i != '0));
  assign wr_cnt = wr_en & (kind == KIND_MCNT);

  // Event code 0 maps to a constant-zero slot, so selector value e picks hpm_event_i[e-1].
  assign ev_pad = EvPadW'({hpm_event_i, 1'b0});

  always_comb begin
    hpm_fire = '0;
    for (int k = 0; k < NumHpmSlots; k++) begin
      hpm_fire[k] = ev_pad[hpm_evt_q[k]];
    end
  end

  function automatic cnt_t next_count(cnt_t cur, logic inc, logic wr, logic hi, logic [31:0] val);
    if (wr) return hi ? {val[HiW-1:0], cur[31:0]} : {cur[CounterWidth-1:32], val};
    return cur + cnt_t'(inc);
  endfunction

  // NOTE: state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mcycle_q    <= '0;
      minstret_q  <= '0;
      inhibit_q   <= '0;
      counteren_q <= '0;
      // NOTE: these arrays are plain flops, not RAM, so every entry is reset.
      for (int k = 0; k < NumHpmSlots; k++) begin
        hpm_cnt_q[k] <= '0;
        hpm_evt_q[k] <= '0;
      end
    end else begin
      mcycle_q   <= next_count(mcycle_q, ~inhibit_q[0],
                               wr_cnt && idx == 5'd0, hi_half, new_val);
      minstret_q <= next_count(minstret_q, instr_retire_i & ~inhibit_q[2],
                               wr_cnt && idx == 5'd2, hi_half, new_val);
      for (int k = 0; k < NumHpmSlots; k++) begin
        if (k < NumHpmCounters) begin
          hpm_cnt_q[k] <= next_count(hpm_cnt_q[k], hpm_fire[k] & ~inhibit_q[k + 3],
                                     wr_cnt && idx == 5'(k + 3), hi_half, new_val);
          if (wr_en && kind == KIND_EVENT && idx == 5'(k + 3)) begin
            hpm_evt_q[k] <= (new_val > 32'(NumEvents)) ? '0 : new_val[EvW-1:0];
          end
        end
      end
      if (wr_en && kind == KIND_INHIBIT)   inhibit_q   <= new_val & ImplMask;
      if (wr_en && kind == KIND_COUNTEREN) counteren_q <= new_val & ImplMask;
    end
  end

  assign csr_hit_o     = hit;
  assign csr_illegal_o = illegal;
  assign csr_rdata_o   = (hit && csr_op_i[2] && !illegal) ? old_val : '0;

endmodule
